dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, read-allocate data cache with a miss-handling state machine. It sits in the memory stage between the M-stage pipeline register (address, store data, byte/word select) and the backing data memory. While an access cannot complete it asserts `stall` to the hazard unit so the pipeline holds. Lines are one 32-bit word; byte and word accesses are supported.

## Interface
Parameters:
- `SETS`, 16: number of lines; a power of two, at least 2. `IDX_W = log2(SETS)`.
- `ADDR_W`, 32: byte address width.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `req_valid`  in  1  — the M stage holds a load or store.
- `we`  in  1  — 1 = store, 0 = load.
- `byte_sel`  in  1  — 1 = byte access, 0 = word access (word accesses are aligned).
- `addr`  in  ADDR_W  — byte address.
- `wdata`  in  32  — store data; for byte stores, bits [7:0] are used.
- `rdata`  out  32  — load data.
- `stall`  out  1  — hold the pipeline; the access is not complete.
- `hit`  out  1  — the lookup in IDLE matched (performance/debug).
- `mem_req`  out  1  — request to the backing memory.
- `mem_we`  out  1  — backing memory write.
- `mem_addr`  out  ADDR_W  — word-aligned address (bits [1:0] = 0).
- `mem_wdata`  out  32  — write data.
- `mem_wstrb`  out  4  — byte write strobes.
- `mem_rdata`  in  32  — read data; valid while `mem_ack` is high.
- `mem_ack`  in  1  — the backing memory completed the request.

## Operation
- Address split:
  - `idx = addr[IDX_W+1:2]`
  - `tag = addr[ADDR_W-1:IDX_W+2]`
  - `hit = req_valid & valid[idx] & (tag_q[idx] == tag)`
- States: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - Load hit: `rdata` is driven combinationally from the line and `stall` = 0.
  - Load miss: `stall` = 1. Register `mem_addr = {addr[ADDR_W-1:2], 2'b00}` and go to FILL.
  - Store (hit or miss): `stall` = 1. Register the address, `mem_wdata` and `mem_wstrb`, then go to WRITE.
  - No request: stay in IDLE with `stall` = 0.
- **FILL**
  - `mem_req` = 1, `mem_we` = 0, `stall` = 1.
  - On `mem_ack`: write `mem_rdata` into the line, write the tag, set valid, and return to IDLE. The load then hits on the next cycle.
- **WRITE**
  - `mem_req` = 1, `mem_we` = 1, `stall` = 1.
  - On `mem_ack`: if the line hits, merge the strobed bytes into it (no allocate on a miss), then go to DONE.
- **DONE**
  - `stall` = 0 for exactly one cycle so the store retires, then go to IDLE.
  - The request is not re-evaluated in DONE.
- Byte store:
  - `mem_wstrb = 4'b0001 << addr[1:0]`
  - `mem_wdata = {4{wdata[7:0]}}`
- Word store: `mem_wstrb = 4'hF`.
- Byte load: zero-extended, `rdata = {24'b0, line[8*addr[1:0] +: 8]}`.
- `mem_req` and `mem_we` are decodes of the registered state, so they are glitch-free.
- `mem_ack` is ignored in IDLE and DONE.

## Timing
- Reset value of every output and all state: IDLE, all valid bits 0, `mem_req`/`mem_we` 0, `mem_addr`/`mem_wdata`/`mem_wstrb` 0. `rdata`, `stall` and `hit` are 0 while `req_valid` = 0.
- Load hit: 0 stall cycles; data is available in the same cycle.
- Miss or store, with `mem_ack` arriving in the k-th cycle of FILL/WRITE (k ≥ 1): exactly k+1 stalled cycles. Within that count:
  - Load miss: the IDLE cycle plus k FILL cycles.
  - Store: the IDLE cycle plus k WRITE cycles, followed by the non-stalled DONE cycle.
- `mem_ack` in the first FILL/WRITE cycle (k=1) is legal.
- Inputs `addr`, `we`, `byte_sel` and `wdata` are held stable by the pipeline while `stall` = 1.
- Reset mid-transaction aborts the transaction immediately:
  - state returns to IDLE and `mem_req` drops asynchronously;
  - the backing memory discards an abandoned request;
  - all lines are invalidated.
- A store followed by a load to the same address in the next instruction reads the merged line (hit) or refills it (miss); stale data is never returned.

## Structure
- Package `dcache_pkg` holds:
  - the state enum `dcache_state_t` (IDLE, FILL, WRITE, DONE);
  - byte-select constants;
  - the function for the strobe/replicate computation.
- Sub-module `dcache_array`: valid, tag and data storage. It has an asynchronous read and a synchronous write with a 4-bit byte-enable, and its valid bits clear on `rst`.
- `dcache_ctrl` contains the FSM, the registered memory-side outputs, and the load-data formatting.

## Test plan
- **Reset, then cold load:** load word 0x40, memory acks after 3 cycles with 0xDEADBEEF. Require:
  - `stall` high for 4 cycles;
  - `mem_addr` = 0x40;
  - then `rdata` = 0xDEADBEEF with `hit` = 1.
- **Repeat load of 0x40:** `stall` = 0, `mem_req` never asserted, `rdata` = 0xDEADBEEF in the same cycle.
- **Byte store 0xAB to 0x42 (line resident):**
  - `mem_wstrb` = 4'b0100, `mem_wdata` = 0xABABABAB;
  - after ack plus DONE, byte-load 0x42 returns 0x000000AB, and word-load 0x40 returns 0xDEABBEEF with no `mem_req`.
- **Conflict miss with SETS=16:** load 0x440 (same index as 0x40) forces a FILL. A later load of 0x40 misses again.
- **Store miss to 0x80:** a write-through request is issued; a subsequent load of 0x80 still misses (no allocate).
- **Reset asserted mid-FILL:** `mem_req` goes low immediately, state is IDLE, and a load of 0x40 then misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-through data cache.
// Holds the controller state encoding and the store strobe/replication rules.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dcache_state_t;

    localparam logic SEL_WORD = 1'b0;
    localparam logic SEL_BYTE = 1'b1;

    function automatic logic [3:0] store_strb(input logic sel, input logic [1:0] off);
        return (sel == SEL_BYTE) ? (4'b0001 << off) : 4'hF;
    endfunction

    // Byte stores replicate the byte on every lane so the strobe alone picks the target.
    function automatic logic [31:0] store_data(input logic sel, input logic [31:0] wdata);
        return (sel == SEL_BYTE) ? {4{wdata[7:0]}} : wdata;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous byte-enabled write.
// A write always marks the line valid; only the valid bits are reset.
module dcache_array #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [TAG_W-1:0] tag_d  [SETS];
    logic [31:0]      data_q [SETS];
    logic [31:0]      data_d [SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, read-allocate data cache controller.
// Load hits complete combinationally; misses fill, stores write through then retire in DONE.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              we,
    input  logic              byte_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    dcache_state_t     state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [31:0]       line_data;
    logic              line_match;
    logic              lookup_hit;
    logic [31:0]       line_shifted;

    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [TAG_W-1:0]  arr_tag;
    logic [3:0]        arr_be;
    logic [31:0]       arr_data;

    assign idx = addr[IDX_W+1:2];
    assign tag = addr[ADDR_W-1:IDX_W+2];

    dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (arr_we),
        .wr_idx   (arr_idx),
        .wr_tag   (arr_tag),
        .wr_be    (arr_be),
        .wr_data  (arr_data)
    );

    assign line_match = line_valid && (line_tag == tag);
    assign lookup_hit = req_valid && line_match;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        stall       = 1'b0;
        arr_we      = 1'b0;
        arr_idx     = mem_addr_q[IDX_W+1:2];
        arr_tag     = mem_addr_q[ADDR_W-1:IDX_W+2];
        arr_be      = 4'hF;
        arr_data    = mem_rdata;
        case (state_q)
            IDLE: begin
                if (req_valid && (we || !lookup_hit)) begin
                    stall      = 1'b1;
                    mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                    if (we) begin
                        mem_wdata_d = store_data(byte_sel, wdata);
                        mem_wstrb_d = store_strb(byte_sel, addr[1:0]);
                        state_d     = WRITE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_ack) begin
                    arr_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                stall    = 1'b1;
                arr_be   = mem_wstrb_q;
                arr_data = mem_wdata_q;
                // Write-through without allocate: only a resident line absorbs the store.
                if (mem_ack) begin
                    arr_we  = line_match;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign mem_req   = (state_q == FILL) || (state_q == WRITE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign hit          = lookup_hit && (state_q == IDLE);
    assign line_shifted = line_data >> {addr[1:0], 3'b000};
    assign rdata        = !hit ? 32'h0 :
                          (byte_sel == SEL_BYTE) ? {24'h0, line_shifted[7:0]} : line_data;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a behavioural memory acks after a chosen number of cycles.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        we;
    logic        byte_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    int          st;
    logic        rq;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [3:0]  ms;
    logic [31:0] rd;
    logic        ht;

    always #5 clk = ~clk;

    dcache_ctrl #(.SETS(16), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .we        (we),
        .byte_sel  (byte_sel),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // One pipeline access; memory acks in the k-th cycle of mem_req. Cycle budget bounds the wait.
    task automatic access(input logic w, input logic bs, input logic [31:0] a,
                          input logic [31:0] wd, input int k, input logic [31:0] fill,
                          output int stalls, output logic req_seen, output logic [31:0] maddr,
                          output logic [31:0] mwdata, output logic [3:0] mstrb,
                          output logic [31:0] rdat, output logic hit_o);
        int cyc;
        int fcyc;
        @(negedge clk);
        req_valid = 1'b1; we = w; byte_sel = bs; addr = a; wdata = wd;
        mem_ack = 1'b0; mem_rdata = fill;
        stalls = 0; req_seen = 1'b0; maddr = '0; mwdata = '0; mstrb = '0;
        cyc = 0; fcyc = 0;
        #1;
        while (stall && cyc < 200) begin
            stalls++;
            cyc++;
            if (mem_req) begin
                req_seen = 1'b1;
                fcyc++;
                maddr  = mem_addr;
                mwdata = mem_wdata;
                mstrb  = mem_wstrb;
                mem_ack = (fcyc == k);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
        end
        rdat  = rdata;
        hit_o = hit;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
            failures++; $display("FAIL reset_mem_regs got=%h/%h/%h exp=0/0/0", mem_addr, mem_wdata, mem_wstrb); end
        checks++; if (stall !== 1'b0 || hit !== 1'b0 || rdata !== 32'h0) begin
            failures++; $display("FAIL reset_idle_outs got=%b/%b/%h exp=0/0/0", stall, hit, rdata); end
        req_valid = 1'b1; addr = 32'h40; #1;
        checks++; if (hit !== 1'b0 || rdata !== 32'h0) begin
            failures++; $display("FAIL reset_invalid_hit got=%b/%h exp=0/0", hit, rdata); end
        req_valid = 1'b0;
    endtask

    task automatic test_cold_load();
        access(1'b0, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 4) begin failures++; $display("FAIL cold_stall got=%0d exp=4", st); end
        checks++; if (rq !== 1'b1 || ma !== 32'h40) begin failures++; $display("FAIL cold_mem_addr got=%b/%h exp=1/00000040", rq, ma); end
        checks++; if (rd !== 32'hDEADBEEF || ht !== 1'b1) begin
            failures++; $display("FAIL cold_rdata got=%h/%b exp=deadbeef/1", rd, ht); end
    endtask

    task automatic test_repeat_load();
        access(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 0 || rq !== 1'b0) begin failures++; $display("FAIL repeat_nostall got=%0d/%b exp=0/0", st, rq); end
        checks++; if (rd !== 32'hDEADBEEF || ht !== 1'b1) begin
            failures++; $display("FAIL repeat_rdata got=%h/%b exp=deadbeef/1", rd, ht); end
    endtask

    task automatic test_byte_store();
        access(1'b1, 1'b1, 32'h42, 32'h123456AB, 2, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 3) begin failures++; $display("FAIL bstore_stall got=%0d exp=3", st); end
        checks++; if (ms !== 4'b0100 || mwd !== 32'hABABABAB || ma !== 32'h40) begin
            failures++; $display("FAIL bstore_mem got=%b/%h/%h exp=0100/abababab/00000040", ms, mwd, ma); end
        access(1'b0, 1'b1, 32'h42, 32'h0, 1, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 0 || rd !== 32'h000000AB) begin
            failures++; $display("FAIL bload_42 got=%0d/%h exp=0/000000ab", st, rd); end
        access(1'b0, 1'b1, 32'h43, 32'h0, 1, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 0 || rd !== 32'h000000DE) begin
            failures++; $display("FAIL bload_43 got=%0d/%h exp=0/000000de", st, rd); end
        access(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (rq !== 1'b0 || rd !== 32'hDEABBEEF) begin
            failures++; $display("FAIL merged_word got=%b/%h exp=0/deabbeef", rq, rd); end
    endtask

    task automatic test_conflict_miss();
        access(1'b0, 1'b0, 32'h440, 32'h0, 1, 32'h11112222, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 2 || ma !== 32'h440) begin failures++; $display("FAIL conflict_fill got=%0d/%h exp=2/00000440", st, ma); end
        checks++; if (rd !== 32'h11112222) begin failures++; $display("FAIL conflict_rdata got=%h exp=11112222", rd); end
        access(1'b0, 1'b0, 32'h40, 32'h0, 2, 32'hDEABBEEF, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 3 || rq !== 1'b1) begin failures++; $display("FAIL conflict_evict got=%0d/%b exp=3/1", st, rq); end
    endtask

    task automatic test_store_miss();
        access(1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 1, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 2 || rq !== 1'b1) begin failures++; $display("FAIL smiss_stall got=%0d/%b exp=2/1", st, rq); end
        checks++; if (ma !== 32'h80 || mwd !== 32'hCAFEF00D || ms !== 4'hF) begin
            failures++; $display("FAIL smiss_mem got=%h/%h/%h exp=00000080/cafef00d/f", ma, mwd, ms); end
        access(1'b0, 1'b0, 32'h80, 32'h0, 1, 32'hCAFEF00D, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 2 || rd !== 32'hCAFEF00D) begin
            failures++; $display("FAIL smiss_noalloc got=%0d/%h exp=2/cafef00d", st, rd); end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 1'b0, 32'h80, 32'h01020304, 1, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 2) begin failures++; $display("FAIL b2b_store got=%0d exp=2", st); end
        access(1'b0, 1'b0, 32'h80, 32'h0, 1, 32'h0, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 0 || rd !== 32'h01020304) begin
            failures++; $display("FAIL b2b_load got=%0d/%h exp=0/01020304", st, rd); end
    endtask

    task automatic test_reset_mid_fill();
        access(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'h55AA55AA, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 2) begin failures++; $display("FAIL rmf_prefill got=%0d exp=2", st); end
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; byte_sel = 1'b0; addr = 32'h540; mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmf_in_fill got=%b exp=1", mem_req); end
        #1 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL rmf_req_drop got=%b/%b exp=0/0", mem_req, mem_we); end
        req_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rmf_idle got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'h55AA55AA, st, rq, ma, mwd, ms, rd, ht);
        checks++; if (st !== 2 || rq !== 1'b1) begin failures++; $display("FAIL rmf_invalidated got=%0d/%b exp=2/1", st, rq); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; we = 1'b0; byte_sel = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_cold_load();
        test_repeat_load();
        test_byte_store();
        test_conflict_miss();
        test_store_miss();
        test_back_to_back();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
